// File: rtl/cndm_mac_tx_tag_if.sv
// cndm_mac_tx_tag_if
//   Bundles the four streams around the MAC TX tag block:
//     s_tx_*  : upstream frame beats plus the upstream request ID (s_tx_tid)
//     m_tx_*  : frame beats to the MAC plus the allocated MAC tag (m_tx_tid)
//     s_cpl_* : MAC TX completions (tag + timestamp)
//     m_cpl_* : completions translated back to request IDs
//   Modports:
//     slave  : the tag block's view (consumes s_*, produces m_*)
//     master : the surrounding core/MAC view
interface cndm_mac_tx_tag_if #(
  parameter int DATA_W   = 64,
  parameter int KEEP_W   = DATA_W/8,
  parameter int TAG_W    = 8,
  parameter int REQ_ID_W = 16,
  parameter int TS_W     = 96
);
  logic [DATA_W-1:0]   s_tx_tdata;
  logic [KEEP_W-1:0]   s_tx_tkeep;
  logic                s_tx_tlast;
  logic                s_tx_tuser;
  logic [REQ_ID_W-1:0] s_tx_tid;
  logic                s_tx_tvalid;
  logic                s_tx_tready;

  logic [DATA_W-1:0]   m_tx_tdata;
  logic [KEEP_W-1:0]   m_tx_tkeep;
  logic                m_tx_tlast;
  logic                m_tx_tuser;
  logic [TAG_W-1:0]    m_tx_tid;
  logic                m_tx_tvalid;
  logic                m_tx_tready;

  logic [TS_W-1:0]     s_cpl_ts;
  logic [TAG_W-1:0]    s_cpl_tid;
  logic                s_cpl_tvalid;
  logic                s_cpl_tready;

  logic [TS_W-1:0]     m_cpl_ts;
  logic [REQ_ID_W-1:0] m_cpl_req_id;
  logic                m_cpl_timeout;
  logic                m_cpl_tvalid;
  logic                m_cpl_tready;

  modport slave (
    input  s_tx_tdata, s_tx_tkeep, s_tx_tlast, s_tx_tuser, s_tx_tid, s_tx_tvalid,
    output s_tx_tready,
    output m_tx_tdata, m_tx_tkeep, m_tx_tlast, m_tx_tuser, m_tx_tid, m_tx_tvalid,
    input  m_tx_tready,
    input  s_cpl_ts, s_cpl_tid, s_cpl_tvalid,
    output s_cpl_tready,
    output m_cpl_ts, m_cpl_req_id, m_cpl_timeout, m_cpl_tvalid,
    input  m_cpl_tready
  );

  modport master (
    output s_tx_tdata, s_tx_tkeep, s_tx_tlast, s_tx_tuser, s_tx_tid, s_tx_tvalid,
    input  s_tx_tready,
    input  m_tx_tdata, m_tx_tkeep, m_tx_tlast, m_tx_tuser, m_tx_tid, m_tx_tvalid,
    output m_tx_tready,
    output s_cpl_ts, s_cpl_tid, s_cpl_tvalid,
    input  s_cpl_tready,
    input  m_cpl_ts, m_cpl_req_id, m_cpl_timeout, m_cpl_tvalid,
    output m_cpl_tready
  );
endinterface

// File: rtl/cndm_mac_tx_tag.sv
// cndm_mac_tx_tag
//   Allocates a MAC transmit tag per frame, remembers the upstream request ID
//   against it, forwards beats to the MAC with that tag and maps MAC
//   completions back to the request ID before freeing the tag.
//   Ports:
//     clk, rst_n            : clock, synchronous active-low reset
//     bus (slave modport)   : s_tx/m_tx frame streams, s_cpl/m_cpl completions
//     stat_outstanding      : number of tags currently allocated
//     stat_err_unknown_tag  : 1-cycle pulse on a completion for a free or
//                             out-of-range tag
//   Optional build macro CNDM_TX_TAG_TIMEOUT_EN adds per-tag age counters and
//   synthesises timeout completions (m_cpl_timeout=1) for tags not completed
//   within TIMEOUT_CYCLES; without it m_cpl_timeout is tied low.
//
//   state    | meaning
//   ST_IDLE  | between frames; next beat handshake allocates a tag
//   ST_FRAME | mid-frame; beats use the held tag until tlast
module cndm_mac_tx_tag #(
  parameter int DATA_W   = 64,
  parameter int KEEP_W   = DATA_W/8,
  parameter int TAG_W    = 8,
  parameter int DEPTH    = 16,
  parameter int REQ_ID_W = 16,
  parameter int TS_W     = 96
`ifdef CNDM_TX_TAG_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cndm_mac_tx_tag_if.slave       bus,
  output logic [$clog2(DEPTH):0] stat_outstanding,
  output logic                   stat_err_unknown_tag
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  state_t              state_q, state_d;
  logic [DEPTH-1:0]    alloc_q, alloc_set, alloc_clr;
  logic [IDX_W-1:0]    cur_tag_q, cand_idx, cpl_idx, free_idx, to_idx;
  logic [REQ_ID_W-1:0] req_tbl [DEPTH];
  logic                in_frame, tag_avail, tx_ok, tx_hs, start_hs;
  logic                cpl_ready, cpl_acc, cpl_hit, to_fire, free_en;
  logic                cpl_vld_q;
  logic [TS_W-1:0]     cpl_ts_q;
  logic [REQ_ID_W-1:0] cpl_rid_q;
  logic [DATA_W-1:0]   tx_data;
  logic [KEEP_W-1:0]   tx_keep;

  assign in_frame  = (state_q == ST_FRAME);
  assign tag_avail = ~&alloc_q;

  // lowest-index free tag; a tag freed this cycle is still marked allocated
  always_comb begin
    cand_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!alloc_q[i]) cand_idx = IDX_W'(i);
    end
  end

  // TX pass-through; only frame starts are gated by tag availability
  assign tx_data            = bus.s_tx_tdata;
  assign tx_keep            = bus.s_tx_tkeep;
  assign bus.m_tx_tdata     = tx_data;
  assign bus.m_tx_tkeep     = tx_keep;
  assign bus.m_tx_tlast     = bus.s_tx_tlast;
  assign bus.m_tx_tuser     = bus.s_tx_tuser;
  assign tx_ok              = in_frame || tag_avail;
  assign bus.m_tx_tvalid    = bus.s_tx_tvalid && tx_ok;
  assign bus.s_tx_tready    = bus.m_tx_tready && tx_ok;
  assign bus.m_tx_tid       = TAG_W'(in_frame ? cur_tag_q : cand_idx);
  assign tx_hs              = bus.s_tx_tvalid && bus.s_tx_tready;
  assign start_hs           = tx_hs && !in_frame;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_hs && !bus.s_tx_tlast) state_d = ST_FRAME;
      ST_FRAME: if (tx_hs && bus.s_tx_tlast)     state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // completion path
  assign cpl_ready        = !cpl_vld_q || bus.m_cpl_tready;
  assign bus.s_cpl_tready = cpl_ready;
  assign cpl_acc          = bus.s_cpl_tvalid && cpl_ready;
  assign cpl_idx          = bus.s_cpl_tid[IDX_W-1:0];
  assign cpl_hit          = (32'(bus.s_cpl_tid) < DEPTH) && alloc_q[cpl_idx];

`ifdef CNDM_TX_TAG_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [AGE_W-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] exp_q;
  logic             cpl_to_q;

  always_comb begin
    to_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (exp_q[i]) to_idx = IDX_W'(i);
    end
  end

  // real completions win; a timeout only uses an otherwise idle output slot
  assign to_fire = cpl_ready && !cpl_acc && (|exp_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_set[i]) begin
          age_q[i] <= '0;
          exp_q[i] <= 1'b0;
        end else if (alloc_clr[i]) begin
          exp_q[i] <= 1'b0;
        end else if (alloc_q[i] && !exp_q[i]) begin
          age_q[i] <= age_q[i] + 1'b1;
          if (age_q[i] == AGE_W'(TIMEOUT_CYCLES - 1)) exp_q[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                 cpl_to_q <= 1'b0;
    else if (cpl_acc && cpl_hit) cpl_to_q <= 1'b0;
    else if (to_fire)           cpl_to_q <= 1'b1;
  end

  assign bus.m_cpl_timeout = cpl_to_q;
`else
  assign to_fire           = 1'b0;
  assign to_idx            = '0;
  assign bus.m_cpl_timeout = 1'b0;
`endif

  assign free_en   = (cpl_acc && cpl_hit) || to_fire;
  assign free_idx  = to_fire ? to_idx : cpl_idx;
  assign alloc_set = start_hs ? (DEPTH'(1) << cand_idx) : '0;
  assign alloc_clr = free_en  ? (DEPTH'(1) << free_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q              <= ST_IDLE;
      cur_tag_q            <= '0;
      alloc_q              <= '0;
      stat_outstanding     <= '0;
      stat_err_unknown_tag <= 1'b0;
      cpl_vld_q            <= 1'b0;
      cpl_ts_q             <= '0;
      cpl_rid_q            <= '0;
    end else begin
      state_q <= state_d;
      if (start_hs) cur_tag_q <= cand_idx;
      alloc_q <= (alloc_q | alloc_set) & ~alloc_clr;
      case ({start_hs, free_en})
        2'b10:   stat_outstanding <= stat_outstanding + CNT_W'(1);
        2'b01:   stat_outstanding <= stat_outstanding - CNT_W'(1);
        default: stat_outstanding <= stat_outstanding;
      endcase
      stat_err_unknown_tag <= cpl_acc && !cpl_hit;
      if (cpl_acc && cpl_hit) begin
        cpl_vld_q <= 1'b1;
        cpl_ts_q  <= bus.s_cpl_ts;
        cpl_rid_q <= req_tbl[cpl_idx];
      end else if (to_fire) begin
        cpl_vld_q <= 1'b1;
        cpl_ts_q  <= '0;
        cpl_rid_q <= req_tbl[to_idx];
      end else if (bus.m_cpl_tready) begin
        cpl_vld_q <= 1'b0;
      end
    end
  end

  // request table needs no reset: entries are only read for allocated tags
  always_ff @(posedge clk) begin
    if (start_hs) req_tbl[cand_idx] <= bus.s_tx_tid;
  end

  assign bus.m_cpl_tvalid = cpl_vld_q;
  assign bus.m_cpl_ts     = cpl_ts_q;
  assign bus.m_cpl_req_id = cpl_rid_q;
endmodule
